// File: rtl/adder_lane_driver.sv
// adder_lane_driver: gathers serial operand beats into a packed lane word,
// issues it to the adder, then streams the packed result back out lane by lane.
module adder_lane_driver #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned LANE_W  = 2,
  parameter int unsigned LATENCY = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [LANE_W-1:0]                            in_data,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  output logic [LANES*LANE_W-1:0]                      op_bus,
  output logic                                         op_valid,
  input  logic [LANES*LANE_W-1:0]                      res_bus,
  output logic [LANE_W-1:0]                            out_data,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_lane,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         busy
);

  localparam int unsigned       CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned       WAIT_W    = 4;
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY);

  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_nxt;
  lanes_t              r_operands;
  lanes_t              w_operands_nxt;
  lanes_t              r_res;
  lanes_t              w_res_nxt;
  lanes_t              r_op_bus;
  lanes_t              w_op_bus_nxt;
  logic                r_op_valid;
  logic                w_op_valid_nxt;
  logic [LANE_W-1:0]   r_out_data;
  logic [LANE_W-1:0]   w_out_data_nxt;
  logic [CNT_W-1:0]    r_out_lane;
  logic [CNT_W-1:0]    w_out_lane_nxt;
  logic                r_out_valid;
  logic                w_out_valid_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  // Operand acceptance is only possible while collecting and out of reset.
  assign in_ready  = (r_state == S_COLLECT) && !reset;

  assign op_bus    = r_op_bus;
  assign op_valid  = r_op_valid;
  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, lane bookkeeping and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cnt_inc       = r_cnt + CNT_W'(1);
    w_wait_nxt      = r_wait;
    w_operands_nxt  = r_operands;
    w_res_nxt       = r_res;
    w_op_bus_nxt    = r_op_bus;
    w_op_valid_nxt  = 1'b0;
    w_out_data_nxt  = r_out_data;
    w_out_lane_nxt  = r_out_lane;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      S_COLLECT: begin
        if (in_valid) begin
          w_operands_nxt[r_cnt] = in_data;
          if (r_cnt == LAST_LANE) begin
            w_cnt_nxt      = '0;
            w_op_bus_nxt   = w_operands_nxt;
            w_op_valid_nxt = 1'b1;
            w_state_nxt    = S_ISSUE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_ISSUE: begin
        w_wait_nxt  = WAIT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Last wait cycle: res_bus now holds the result of the issued word.
        if (r_wait <= WAIT_W'(1)) begin
          w_wait_nxt      = '0;
          w_res_nxt       = lanes_t'(res_bus);
          w_out_data_nxt  = res_bus[LANE_W-1:0];
          w_out_lane_nxt  = '0;
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_DRAIN;
        end else begin
          w_wait_nxt = r_wait - WAIT_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (r_cnt == LAST_LANE) begin
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_COLLECT;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_out_lane_nxt = w_cnt_inc;
            w_out_data_nxt = r_res[w_cnt_inc];
          end
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_COLLECT) || (w_cnt_nxt != '0);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_wait      <= '0;
      r_operands  <= '0;
      r_res       <= '0;
      r_op_bus    <= '0;
      r_op_valid  <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_wait      <= w_wait_nxt;
      r_operands  <= w_operands_nxt;
      r_res       <= w_res_nxt;
      r_op_bus    <= w_op_bus_nxt;
      r_op_valid  <= w_op_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_lane  <= w_out_lane_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_adder_lane_driver.sv
// tb_adder_lane_driver: directed scenarios against a LATENCY=1 and a LATENCY=3 instance.
module tb_adder_lane_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // LATENCY = 1 instance
  logic [1:0] in_data1;
  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] op_bus1;
  logic       op_valid1;
  logic [7:0] res_bus1;
  logic [7:0] res_drv1;
  logic       mirror1;
  logic [1:0] out_data1;
  logic [1:0] out_lane1;
  logic       out_valid1;
  logic       out_ready1;
  logic       busy1;

  assign res_bus1 = mirror1 ? op_bus1 : res_drv1;

  adder_lane_driver #(.LANES(4), .LANE_W(2), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_bus(op_bus1), .op_valid(op_valid1), .res_bus(res_bus1),
    .out_data(out_data1), .out_lane(out_lane1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1)
  );

  // LATENCY = 3 instance
  logic [1:0] in_data3;
  logic       in_valid3;
  logic       in_ready3;
  logic [7:0] op_bus3;
  logic       op_valid3;
  logic [7:0] res_bus3;
  logic [1:0] out_data3;
  logic [1:0] out_lane3;
  logic       out_valid3;
  logic       out_ready3;
  logic       busy3;

  adder_lane_driver #(.LANES(4), .LANE_W(2), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .op_bus(op_bus3), .op_valid(op_valid3), .res_bus(res_bus3),
    .out_data(out_data3), .out_lane(out_lane3), .out_valid(out_valid3),
    .out_ready(out_ready3), .busy(busy3)
  );

  // Recorders: issued words and accepted result beats with their cycle numbers.
  logic [7:0] m1_ops[$];
  logic [1:0] m1_data[$];
  logic [1:0] m1_lane[$];
  int         m1_cyc[$];
  int         m1_opv_cyc = 0;
  logic [7:0] m3_ops[$];
  logic [1:0] m3_data[$];
  logic [1:0] m3_lane[$];
  int         m3_cyc[$];
  int         m3_opv_cyc = 0;

  always @(negedge clk) begin
    if (op_valid1) begin
      m1_ops.push_back(op_bus1);
      m1_opv_cyc = cyc;
    end
    if (out_valid1 && out_ready1) begin
      m1_data.push_back(out_data1);
      m1_lane.push_back(out_lane1);
      m1_cyc.push_back(cyc);
    end
    if (op_valid3) begin
      m3_ops.push_back(op_bus3);
      m3_opv_cyc = cyc;
    end
    if (out_valid3 && out_ready3) begin
      m3_data.push_back(out_data3);
      m3_lane.push_back(out_lane3);
      m3_cyc.push_back(cyc);
    end
  end

  // Drive one operand beat into instance 1 and hold it until accepted.
  task automatic send1(input logic [1:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    in_data1  = d;
    @(negedge clk);
    while (in_ready1 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (in_ready1 !== 1'b1) begin
      n_checks++;
      $display("FAIL send1_timeout: in_ready=%b required 1", in_ready1);
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_data1  = 2'd0;
  endtask

  // Drive one operand beat into instance 3 and hold it until accepted.
  task automatic send3(input logic [1:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid3 = 1'b1;
    in_data3  = d;
    @(negedge clk);
    while (in_ready3 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (in_ready3 !== 1'b1) begin
      n_checks++;
      $display("FAIL send3_timeout: in_ready=%b required 1", in_ready3);
    end
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    in_data3  = 2'd0;
  endtask

  // Wait (bounded) until instance 1 has delivered n beats in total.
  task automatic wait_beats1(input int n);
    int k;
    k = 0;
    while (m1_data.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (m1_data.size() < n) begin
      n_checks++;
      $display("FAIL wait_beats1_timeout: beats=%0d required %0d", m1_data.size(), n);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_valid1  = 1'b1;
    in_data1   = 2'd3;
    out_ready1 = 1'b1;
    res_drv1   = 8'h00;
    mirror1    = 1'b0;
    in_valid3  = 1'b1;
    in_data3   = 2'd3;
    out_ready3 = 1'b1;
    res_bus3   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready1, op_valid1, out_valid1, busy1, op_bus1, out_data1, out_lane1} !== 16'h0000)
      $display("FAIL reset_outputs1: rdy=%b opv=%b outv=%b busy=%b op=%h od=%h ol=%h required all 0",
               in_ready1, op_valid1, out_valid1, busy1, op_bus1, out_data1, out_lane1);
    else n_pass++;
    n_checks++;
    if ({in_ready3, op_valid3, out_valid3, busy3, op_bus3, out_data3, out_lane3} !== 16'h0000)
      $display("FAIL reset_outputs3: rdy=%b opv=%b outv=%b busy=%b op=%h required all 0",
               in_ready3, op_valid3, out_valid3, busy3, op_bus3);
    else n_pass++;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_valid3 = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready1, busy1, op_valid1} !== 3'b100)
      $display("FAIL reset_release: rdy=%b busy=%b opv=%b required 1,0,0", in_ready1, busy1, op_valid1);
    else n_pass++;
  endtask

  task automatic test_basic();
    int b, o;
    logic [1:0] exp_d [4];
    b = m1_data.size();
    o = m1_ops.size();
    res_drv1   = 8'hE4;
    out_ready1 = 1'b1;
    send1(2'd1); send1(2'd2); send1(2'd3); send1(2'd0);
    wait_beats1(b + 4);
    repeat (2) @(negedge clk);
    exp_d = '{2'd0, 2'd1, 2'd2, 2'd3};
    n_checks++;
    if (m1_ops.size() - o != 1) $display("FAIL basic_opv_count: got %0d required 1", m1_ops.size() - o);
    else n_pass++;
    n_checks++;
    if (m1_ops[o] !== 8'h39) $display("FAIL basic_op_bus: got %h required 39", m1_ops[o]);
    else n_pass++;
    n_checks++;
    if (op_bus1 !== 8'h39) $display("FAIL basic_op_hold: got %h required 39", op_bus1);
    else n_pass++;
    n_checks++;
    if (m1_cyc[b] - m1_opv_cyc != 2)
      $display("FAIL basic_latency: op_valid->out_valid %0d cycles required 2", m1_cyc[b] - m1_opv_cyc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m1_data[b+i] !== exp_d[i] || m1_lane[b+i] !== 2'(i))
        $display("FAIL basic_beat%0d: data=%0d lane=%0d required data=%0d lane=%0d",
                 i, m1_data[b+i], m1_lane[b+i], exp_d[i], i);
      else n_pass++;
    end
    n_checks++;
    if ({busy1, out_valid1, in_ready1} !== 3'b001)
      $display("FAIL basic_idle: busy=%b outv=%b rdy=%b required 0,0,1", busy1, out_valid1, in_ready1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int b, k;
    b = m1_data.size();
    res_drv1   = 8'hE4;
    out_ready1 = 1'b1;
    send1(2'd1); send1(2'd2); send1(2'd3); send1(2'd0);
    k = 0;
    @(negedge clk);
    while (!(out_valid1 && out_lane1 == 2'd0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!(out_valid1 && out_lane1 == 2'd0)) begin
      n_checks++;
      $display("FAIL bp_lane0_timeout: outv=%b lane=%0d required 1,0", out_valid1, out_lane1);
    end
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid1, out_lane1, out_data1} !== 5'b1_01_01)
        $display("FAIL bp_hold%0d: outv=%b lane=%0d data=%0d required 1,1,1", i, out_valid1, out_lane1, out_data1);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready1 = 1'b1;
    wait_beats1(b + 4);
    repeat (3) @(negedge clk);
    n_checks++;
    if (m1_data.size() - b != 4) $display("FAIL bp_beat_count: got %0d required 4", m1_data.size() - b);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m1_data[b+i] !== 2'(i) || m1_lane[b+i] !== 2'(i))
        $display("FAIL bp_beat%0d: data=%0d lane=%0d required %0d,%0d", i, m1_data[b+i], m1_lane[b+i], i, i);
      else n_pass++;
    end
  endtask

  task automatic test_input_gaps();
    int b, o;
    logic       vld [7];
    logic [1:0] exp_d [4];
    b = m1_data.size();
    o = m1_ops.size();
    vld   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_d = '{2'd3, 2'd0, 2'd1, 2'd2};
    res_drv1   = 8'h93;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      in_valid1 = vld[i];
      in_data1  = vld[i] ? 2'd3 : 2'd0;
      @(negedge clk);
      n_checks++;
      if ({in_ready1, op_valid1} !== 2'b10)
        $display("FAIL gaps_collect%0d: rdy=%b opv=%b required 1,0", i, in_ready1, op_valid1);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL gaps_busy_partial: busy=%b required 1", busy1);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    in_data1  = 2'd0;
    @(negedge clk);
    n_checks++;
    if ({op_valid1, op_bus1, in_ready1} !== 10'b1_11111111_0)
      $display("FAIL gaps_issue: opv=%b op=%h rdy=%b required 1,ff,0", op_valid1, op_bus1, in_ready1);
    else n_pass++;
    wait_beats1(b + 4);
    repeat (2) @(negedge clk);
    n_checks++;
    if (m1_ops.size() - o != 1) $display("FAIL gaps_opv_count: got %0d required 1", m1_ops.size() - o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m1_data[b+i] !== exp_d[i] || m1_lane[b+i] !== 2'(i))
        $display("FAIL gaps_beat%0d: data=%0d lane=%0d required %0d,%0d", i, m1_data[b+i], m1_lane[b+i], exp_d[i], i);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    int b, o, k;
    logic [1:0] exp_d [4];
    b = m3_data.size();
    o = m3_ops.size();
    exp_d = '{2'd3, 2'd2, 2'd1, 2'd0};
    res_bus3   = 8'h00;
    out_ready3 = 1'b1;
    send3(2'd0); send3(2'd1); send3(2'd2); send3(2'd3);
    k = 0;
    @(negedge clk);
    while (!op_valid3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if ({op_valid3, op_bus3} !== 9'b1_11100100)
      $display("FAIL lat_issue: opv=%b op=%h required 1,e4", op_valid3, op_bus3);
    else n_pass++;
    @(posedge clk); #1; res_bus3 = 8'h00;
    @(posedge clk); #1; res_bus3 = 8'hAA;
    @(posedge clk); #1; res_bus3 = 8'h1B;
    @(posedge clk); #1; res_bus3 = 8'h00;
    k = 0;
    while (m3_data.size() < b + 4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (m3_data.size() - b != 4) $display("FAIL lat_beat_count: got %0d required 4", m3_data.size() - b);
    else n_pass++;
    n_checks++;
    if (m3_ops.size() - o != 1) $display("FAIL lat_opv_count: got %0d required 1", m3_ops.size() - o);
    else n_pass++;
    n_checks++;
    if (m3_cyc[b] - m3_opv_cyc != 4)
      $display("FAIL lat_delay: op_valid->out_valid %0d cycles required 4", m3_cyc[b] - m3_opv_cyc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m3_data[b+i] !== exp_d[i] || m3_lane[b+i] !== 2'(i))
        $display("FAIL lat_beat%0d: data=%0d lane=%0d required %0d,%0d", i, m3_data[b+i], m3_lane[b+i], exp_d[i], i);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int b, o, k;
    logic [1:0] exp_d [4];
    out_ready1 = 1'b1;
    // Abort while waiting for the result.
    b = m1_data.size();
    res_drv1 = 8'hFF;
    send1(2'd0); send1(2'd0); send1(2'd0); send1(2'd0);
    k = 0;
    @(negedge clk);
    while (!op_valid1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready1, op_valid1, out_valid1, busy1, op_bus1, out_data1, out_lane1} !== 16'h0000)
      $display("FAIL abort_wait: rdy=%b opv=%b outv=%b busy=%b op=%h od=%h ol=%h required all 0",
               in_ready1, op_valid1, out_valid1, busy1, op_bus1, out_data1, out_lane1);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({op_valid1, out_valid1, busy1, in_ready1} !== 4'b0001)
        $display("FAIL abort_wait_after%0d: opv=%b outv=%b busy=%b rdy=%b required 0,0,0,1",
                 i, op_valid1, out_valid1, busy1, in_ready1);
      else n_pass++;
    end
    n_checks++;
    if (m1_data.size() != b) $display("FAIL abort_wait_beats: got %0d required 0", m1_data.size() - b);
    else n_pass++;

    // Abort in the middle of draining, after lane 1 was accepted.
    b = m1_data.size();
    res_drv1 = 8'h1B;
    send1(2'd1); send1(2'd1); send1(2'd1); send1(2'd1);
    k = 0;
    @(negedge clk);
    while (!(out_valid1 && out_lane1 == 2'd1) && k < 30) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready1, op_valid1, out_valid1, busy1, op_bus1, out_data1, out_lane1} !== 16'h0000)
      $display("FAIL abort_drain: rdy=%b opv=%b outv=%b busy=%b op=%h od=%h ol=%h required all 0",
               in_ready1, op_valid1, out_valid1, busy1, op_bus1, out_data1, out_lane1);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({op_valid1, out_valid1} !== 2'b00)
        $display("FAIL abort_drain_after%0d: opv=%b outv=%b required 0,0", i, op_valid1, out_valid1);
      else n_pass++;
    end
    n_checks++;
    if (m1_data.size() - b != 2) $display("FAIL abort_drain_beats: got %0d required 2", m1_data.size() - b);
    else n_pass++;

    // Fresh transaction after the abort.
    b = m1_data.size();
    o = m1_ops.size();
    exp_d = '{2'd1, 2'd0, 2'd3, 2'd2};
    res_drv1 = 8'hB1;
    send1(2'd2); send1(2'd3); send1(2'd0); send1(2'd1);
    wait_beats1(b + 4);
    repeat (2) @(negedge clk);
    n_checks++;
    if (m1_ops.size() - o != 1 || m1_ops[o] !== 8'h4E)
      $display("FAIL abort_fresh_op: count=%0d op=%h required 1,4e", m1_ops.size() - o, m1_ops[o]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m1_data[b+i] !== exp_d[i] || m1_lane[b+i] !== 2'(i))
        $display("FAIL abort_fresh_beat%0d: data=%0d lane=%0d required %0d,%0d",
                 i, m1_data[b+i], m1_lane[b+i], exp_d[i], i);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int b, o, k, rdy_cyc;
    b = m1_data.size();
    o = m1_ops.size();
    mirror1    = 1'b1;
    out_ready1 = 1'b1;
    send1(2'd1); send1(2'd1); send1(2'd1); send1(2'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    in_data1  = 2'd2;
    k = 0;
    @(negedge clk);
    while (in_ready1 !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    rdy_cyc = cyc;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_data1  = 2'd0;
    send1(2'd2); send1(2'd2); send1(2'd2);
    wait_beats1(b + 8);
    repeat (2) @(negedge clk);
    n_checks++;
    if (rdy_cyc != m1_cyc[b+3] + 1)
      $display("FAIL b2b_ready: in_ready cycle %0d required %0d", rdy_cyc, m1_cyc[b+3] + 1);
    else n_pass++;
    n_checks++;
    if (m1_ops.size() - o != 2 || m1_ops[o] !== 8'h55 || m1_ops[o+1] !== 8'hAA)
      $display("FAIL b2b_ops: count=%0d op0=%h op1=%h required 2,55,aa", m1_ops.size() - o, m1_ops[o], m1_ops[o+1]);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (m1_data[b+i] !== ((i < 4) ? 2'd1 : 2'd2) || m1_lane[b+i] !== 2'(i % 4))
        $display("FAIL b2b_beat%0d: data=%0d lane=%0d required %0d,%0d",
                 i, m1_data[b+i], m1_lane[b+i], (i < 4) ? 1 : 2, i % 4);
      else n_pass++;
    end
    mirror1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_input_gaps();
    test_latency();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
